slot_spin_generator: RTL and testbench



---
 rtl/slot_spin_generator_if.sv | 22 ++
 rtl/slot_spin_generator.sv | 182 ++++++++++++++++++
 tb/tb_slot_spin_generator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/slot_spin_generator_if.sv
// Bus between the slot-machine control FSM (master) and the spin generator (slave).
interface slot_spin_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic [11:0] reel_live;
  logic [11:0] spin_number;
  logic [1:0]  reels_stopped;
  logic        busy;
  logic        spin_valid;
  logic        done;

  modport master (
    output start, stop, clear,
    input  reel_live, spin_number, reels_stopped, busy, spin_valid, done
  );

  modport slave (
    input  start, stop, clear,
    output reel_live, spin_number, reels_stopped, busy, spin_valid, done
  );
endinterface

// File: rtl/slot_spin_generator.sv
// Three-reel spin generator: LFSR-seeded rolling reels frozen one by one by spacebar presses.
// Optional SPIN_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability window on the synchronised stop.
module slot_spin_generator #(
  parameter int unsigned REEL_SYMBOLS    = 10,
  parameter int unsigned ROLL_DIV        = 2500000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic        CLOCK_50,
  input logic        resetn,
  slot_spin_if.slave bus
);

  localparam int unsigned DIV_W     = $clog2(ROLL_DIV);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_e;
  typedef logic [3:0] reel_t;

  if (REEL_SYMBOLS < 8 || REEL_SYMBOLS > 16) begin : g_bad_symbols
    $error("slot_spin_generator: REEL_SYMBOLS must be 8..16");
  end
  if (ROLL_DIV < 2) begin : g_bad_div
    $error("slot_spin_generator: ROLL_DIV must be at least 2");
  end
  if (LFSR_SEED == 16'h0000 || DEBOUNCE_CYCLES < 1) begin : g_bad_seed
    $error("slot_spin_generator: LFSR_SEED must be nonzero and DEBOUNCE_CYCLES positive");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Folds a raw LFSR nibble into the legal symbol range.
  function automatic reel_t fold(input reel_t n);
    fold = (int'(n) >= int'(REEL_SYMBOLS)) ? n - reel_t'(REEL_SYMBOLS) : n;
  endfunction

  function automatic reel_t reel_step(input reel_t r);
    reel_step = (r == reel_t'(REEL_SYMBOLS - 1)) ? '0 : r + 1'b1;
  endfunction

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [2:0][3:0]        reel_q, reel_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             stopped_q, stopped_d;
  logic [11:0]            spin_number_q, spin_number_d;
  logic                   done_q, done_d;
  logic                   stop_meta_q, stop_sync_q;
  logic                   stop_edge;
  logic                   terminal;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      stop_meta_q <= 1'b0;
      stop_sync_q <= 1'b0;
    end else begin
      stop_meta_q <= bus.stop;
      stop_sync_q <= stop_meta_q;
    end
  end

`ifdef SPIN_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q;

  // The debounced level only follows after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (stop_sync_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) deb_d = stop_sync_q;
      else                                           deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      deb_prev_q <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_prev_q <= deb_q;
    end
  end

  assign stop_edge = deb_q & ~deb_prev_q;
`else
  logic stop_prev_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) stop_prev_q <= 1'b0;
    else         stop_prev_q <= stop_sync_q;
  end

  // Requiring the first stage high too rejects presses shorter than two cycles.
  assign stop_edge = stop_sync_q & stop_meta_q & ~stop_prev_q;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d       = state_q;
    lfsr_d        = lfsr_step(lfsr_q);
    reel_d        = reel_q;
    div_d         = div_q;
    stopped_d     = stopped_q;
    spin_number_d = spin_number_q;
    done_d        = 1'b0;
    terminal      = (div_q == DIV_W'(ROLL_DIV - 1));

    if (bus.clear) begin
      state_d       = IDLE;
      reel_d        = '0;
      div_d         = '0;
      stopped_d     = '0;
      spin_number_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d   = SPIN;
            div_d     = '0;
            stopped_d = '0;
            for (int i = 0; i < 3; i++) reel_d[i] = fold(lfsr_q[4*i +: 4]);
          end
        end
        SPIN: begin
          div_d = terminal ? '0 : div_q + 1'b1;
          // A reel being frozen on a terminal count keeps its pre-step value.
          for (int i = 0; i < 3; i++) begin
            if (terminal && (i >= int'(stopped_q)) && !(stop_edge && (i == int'(stopped_q))))
              reel_d[i] = reel_step(reel_q[i]);
          end
          if (stop_edge) begin
            stopped_d = stopped_q + 1'b1;
            if (stopped_q == 2'd2) begin
              state_d       = DONE;
              spin_number_d = reel_q;
              done_d        = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      reel_q        <= '0;
      div_q         <= '0;
      stopped_q     <= '0;
      spin_number_q <= '0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      reel_q        <= reel_d;
      div_q         <= div_d;
      stopped_q     <= stopped_d;
      spin_number_q <= spin_number_d;
      done_q        <= done_d;
    end
  end

  assign bus.reel_live     = reel_q;
  assign bus.spin_number   = spin_number_q;
  assign bus.reels_stopped = stopped_q;
  assign bus.busy          = (state_q == SPIN);
  assign bus.spin_valid    = (state_q == DONE);
  assign bus.done          = done_q;

endmodule

// File: tb/tb_slot_spin_generator.sv
// Directed bench for slot_spin_generator: cycle model plus a spin_number scoreboard.
// Build with SPIN_DEBOUNCE_EN defined to exercise the debounced stop path.
module tb_slot_spin_generator;

  localparam int          N    = 10;
  localparam int          RD   = 4;
  localparam int          DEB  = 8;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SPIN_DEBOUNCE_EN
  localparam int LAT = DEB + 3, MIN_PRESS = DEB, PLEN = 12, GLITCH = 5;
`else
  localparam int LAT = 3, MIN_PRESS = 2, PLEN = 5, GLITCH = 1;
`endif
  localparam int S_IDLE = 0, S_SPIN = 1, S_DONE = 2;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;

  slot_spin_if bus ();

  slot_spin_generator #(
    .REEL_SYMBOLS(N), .ROLL_DIV(RD), .LFSR_SEED(SEED), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int vectors = 0;
  int miscompares = 0;

  int          m_state, m_div, m_stop, frz_cd;
  logic [3:0]  m_reel [3];
  logic [11:0] m_spin;
  logic        m_done;
  logic [15:0] m_lfsr;
  logic [11:0] exp_q [$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [11:0] pack();
    return {m_reel[2], m_reel[1], m_reel[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_div = 0; m_stop = 0; frz_cd = 0;
    for (int i = 0; i < 3; i++) m_reel[i] = '0;
    m_spin = '0; m_done = 1'b0; m_lfsr = SEED;
  endtask

  // Reference behaviour for one clock edge, using the inputs held across it.
  task automatic model_edge();
    logic fire, term;
    fire = 1'b0;
    if (frz_cd > 0) begin
      frz_cd--;
      fire = (frz_cd == 0);
    end
    m_done = 1'b0;
    if (bus.clear) begin
      m_state = S_IDLE; m_div = 0; m_stop = 0; m_spin = '0;
      for (int i = 0; i < 3; i++) m_reel[i] = '0;
    end else if (m_state == S_SPIN) begin
      term  = (m_div == RD - 1);
      m_div = term ? 0 : m_div + 1;
      for (int i = 0; i < 3; i++)
        if (term && i >= m_stop && !(fire && i == m_stop))
          m_reel[i] = (m_reel[i] == 4'(N - 1)) ? 4'd0 : m_reel[i] + 4'd1;
      if (fire) begin
        m_stop++;
        if (m_stop == 3) begin
          m_state = S_DONE; m_done = 1'b1; m_spin = pack();
          exp_q.push_back(pack());
        end
      end
    end else if (bus.start) begin
      m_state = S_SPIN; m_div = 0; m_stop = 0;
      for (int i = 0; i < 3; i++) begin
        logic [3:0] nib;
        nib = m_lfsr[4*i +: 4];
        m_reel[i] = (nib >= 4'(N)) ? nib - 4'(N) : nib;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    check("reel_live", bus.reel_live, pack());
    check("spin_number", bus.spin_number, m_spin);
    check("reels_stopped", bus.reels_stopped, m_stop);
    check("busy", bus.busy, m_state == S_SPIN);
    check("spin_valid", bus.spin_valid, m_state == S_DONE);
    check("done", bus.done, m_done);
    for (int i = 0; i < 3; i++) check("reel_in_range", bus.reel_live[4*i +: 4] <= 4'(N - 1), 1'b1);
    if (bus.done) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("sb_spin_number", bus.spin_number, exp_q.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    if (resetn) model_edge();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic press(input int len, input int gap);
    bus.stop = 1'b1;
    if (len >= MIN_PRESS) frz_cd = LAT;
    repeat (len) cycle();
    bus.stop = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] snap [3];
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    model_reset();

    // Reset, then 100 idle cycles.
    repeat (3) cycle();
    resetn = 1'b1;
    cycle();
    check("lfsr_after_1", dut.lfsr_q, m_lfsr);
    check("lfsr_left_seed", dut.lfsr_q != SEED, 1'b1);
    repeat (99) cycle();

    // Spin 1: a glitch is ignored, then three clean presses finish the spin.
    pulse_start();
    check("busy_after_start", bus.busy, 1'b1);
    repeat (10) cycle();
    press(GLITCH, 12);
    check("glitch_no_freeze", bus.reels_stopped, 2'd0);
    for (int k = 0; k < 3; k++) press(PLEN, 15);
    check("spin1_done_state", bus.spin_valid, 1'b1);
    check("spin1_sb_drained", exp_q.size(), 0);

    // stop is ignored while DONE.
    press(PLEN, 15);
    check("done_ignores_stop", bus.reels_stopped, 2'd3);

    // Spin 2: freeze aligned to a terminal count, start ignored mid-spin.
    pulse_start();
    repeat (3) cycle();
    pulse_start();
    for (int g = 0; g < RD && ((m_div + LAT - 1) % RD != RD - 1); g++) cycle();
    bus.stop = 1'b1;
    frz_cd = LAT;
    repeat (LAT - 1) cycle();
    for (int i = 0; i < 3; i++) snap[i] = m_reel[i];
    cycle();
    check("tc_frozen_holds", bus.reel_live[3:0], snap[0]);
    check("tc_reel1_steps", bus.reel_live[7:4], (snap[1] == 4'(N - 1)) ? 4'd0 : snap[1] + 4'd1);
    check("tc_reel2_steps", bus.reel_live[11:8], (snap[2] == 4'(N - 1)) ? 4'd0 : snap[2] + 4'd1);
    bus.stop = 1'b0;
    repeat (15) cycle();
    press(PLEN, 15);
    check("two_frozen", bus.reels_stopped, 2'd2);

    // clear beats start in the same cycle.
    bus.clear = 1'b1; bus.start = 1'b1;
    cycle();
    bus.clear = 1'b0; bus.start = 1'b0;
    check("clear_live", bus.reel_live, 12'd0);
    check("clear_spin_number", bus.spin_number, 12'd0);
    check("clear_busy", bus.busy, 1'b0);
    repeat (5) cycle();

    // Spin 3: asynchronous reset mid-spin.
    pulse_start();
    press(PLEN, 15);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("reset_mid_spin_stopped", bus.reels_stopped, 2'd0);
    repeat (3) cycle();
    resetn = 1'b1;
    repeat (5) cycle();

    // Spin 4: recovery after reset.
    pulse_start();
    for (int k = 0; k < 3; k++) press(PLEN, 15);
    repeat (3) cycle();
    check("final_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
